// File: rtl/spi_rx_frame_fifo.sv
// SPI receive deserialiser (4..MAX_DW-bit frames, MSB/LSB first) feeding a FWFT FIFO.
// Define SPI_RX_FIFO_THR_EN to add the FIFO level threshold interrupt (rx_thr / rx_thr_irq).
module spi_rx_frame_fifo #(
  parameter int unsigned MAX_DW     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 13
) (
  input  logic                        clk_rx,
  input  logic                        spi_rx_rstn,
  input  logic                        rx_en,
  input  logic [4:0]                  frame_len,
  input  logic                        lsbf,
  input  logic [CNT_W-1:0]            spi_tnum,
  input  logic                        shift_in,
  input  logic                        rd_en,
  output logic [MAX_DW-1:0]           rd_data,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovr_flag,
  input  logic                        ovr_clr,
  output logic                        rx_busy,
  output logic                        rx_done
`ifdef SPI_RX_FIFO_THR_EN
  ,
  input  logic [$clog2(FIFO_DEPTH):0] rx_thr,
  output logic                        rx_thr_irq
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [4:0]        flen_q, flen_d;
  logic [4:0]        cur_flen, pos;
  logic [MAX_DW-1:0] shreg_q, shreg_d, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rx_busy_q, rx_busy_d;
  logic              ovr_q, ovr_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [MAX_DW-1:0] mem_q [FIFO_DEPTH];
  logic              frame_done, pop, push_ok;

  // On the first bit of a frame the live frame_len applies; it is captured for the rest.
  always_comb begin
    cur_flen   = (bit_cnt_q == '0) ? frame_len : flen_q;
    flen_d     = cur_flen;
    pos        = lsbf ? bit_cnt_q : (cur_flen - bit_cnt_q);
    word       = ((bit_cnt_q == '0) ? '0 : shreg_q) | (MAX_DW'(shift_in) << pos);
    frame_done = rx_en && (bit_cnt_q == cur_flen);

    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    if (!rx_en) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
      cnt_d     = '0;
    end else if (frame_done) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
      if (!rx_done) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      shreg_d   = word;
    end
    rx_busy_d = (bit_cnt_d != '0);
  end

  assign rx_done    = (cnt_q >= spi_tnum);
  assign rx_busy    = rx_busy_q;
  assign ovr_flag   = ovr_q;
  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
  assign rd_data    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so a push into a full FIFO with a pop is legal.
  always_comb begin
    pop      = rd_en && !fifo_empty;
    push_ok  = frame_done && (!fifo_full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    ovr_d    = ovr_q;
    if (frame_done && fifo_full && !pop) ovr_d = 1'b1;
    else if (ovr_clr)                    ovr_d = 1'b0;
  end

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) begin
      bit_cnt_q <= '0;
      flen_q    <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      rx_busy_q <= 1'b0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      flen_q    <= flen_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      rx_busy_q <= rx_busy_d;
      ovr_q     <= ovr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= word;
  end

`ifdef SPI_RX_FIFO_THR_EN
  logic thr_irq_q;

  always_ff @(posedge clk_rx or negedge spi_rx_rstn) begin
    if (!spi_rx_rstn) thr_irq_q <= 1'b0;
    else              thr_irq_q <= (level >= rx_thr) && (rx_thr != '0);
  end

  assign rx_thr_irq = thr_irq_q;
`endif

endmodule

// File: tb/tb_spi_rx_frame_fifo.sv
// Directed bench for spi_rx_frame_fifo: expected words queued by stimulus, checked on every pop.
module tb_spi_rx_frame_fifo;

  logic        clk_rx = 1'b0;
  logic        spi_rx_rstn = 1'b0;
  logic        rx_en = 1'b0;
  logic [4:0]  frame_len = 5'd7;
  logic        lsbf = 1'b0;
  logic [12:0] spi_tnum = '0;
  logic        shift_in = 1'b0;
  logic        rd_en = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [31:0] rd_data;
  logic        fifo_empty, fifo_full, ovr_flag, rx_busy, rx_done;
  logic [3:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  spi_rx_frame_fifo #(.MAX_DW(32), .FIFO_DEPTH(8), .CNT_W(13)) dut (
    .clk_rx(clk_rx), .spi_rx_rstn(spi_rx_rstn), .rx_en(rx_en), .frame_len(frame_len),
    .lsbf(lsbf), .spi_tnum(spi_tnum), .shift_in(shift_in), .rd_en(rd_en),
    .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .ovr_flag(ovr_flag), .ovr_clr(ovr_clr),
    .rx_busy(rx_busy), .rx_done(rx_done)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk_rx) begin
    if (spi_rx_rstn && rd_en && !fifo_empty) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
      end else begin
        chk("pop_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b, input logic [4:0] fl);
    rx_en = 1'b1;
    shift_in = b;
    frame_len = fl;
    @(posedge clk_rx); #1;
  endtask

  // ser holds the bits in wire order: ser[len-1] goes out first.
  task automatic send_frame(input int unsigned len, input logic [31:0] ser,
                            input logic lsb_first, input bit pop_last);
    lsbf = lsb_first;
    for (int unsigned k = 0; k < len; k++) begin
      if (pop_last && k == len - 1) rd_en = 1'b1;
      send_bit(ser[len-1-k], 5'(len - 1));
    end
    rd_en = 1'b0;
    rx_en = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(posedge clk_rx); #1;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    rx_en = 1'b0;
    repeat (n) begin
      @(posedge clk_rx); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    #2;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovr", ovr_flag, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_done_tnum0", rx_done, 1);
    chk("rst_rd_data", rd_data, 0);
    #10 spi_rx_rstn = 1'b1;
    @(posedge clk_rx); #1;

    // 1: MSB-first byte 1,0,1,0,0,1,0,1
    exp_q.push_back(32'h0000_00A5);
    send_frame(8, 32'hA5, 1'b0, 0);
    chk("t1_peek", rd_data, 32'h0000_00A5);
    chk("t1_level", fifo_level, 1);
    chk("t1_busy", rx_busy, 0);
    chk("t1_empty", fifo_empty, 0);
    pop_one();

    // 2: 12-bit 0xABC LSB first (wire order 0x3D5), then MSB first
    exp_q.push_back(32'h0000_0ABC);
    send_frame(12, 32'h3D5, 1'b1, 0);
    chk("t2_lsb_peek", rd_data, 32'h0000_0ABC);
    pop_one();
    exp_q.push_back(32'h0000_0ABC);
    send_frame(12, 32'hABC, 1'b0, 0);
    pop_one();
    chk("t2_empty", fifo_empty, 1);
    idle(2);

    // 3: overrun with nine bytes 0x11..0x99
    for (int i = 1; i <= 9; i++) begin
      v = 32'(i * 17);
      if (i <= 8) exp_q.push_back(v);
      send_frame(8, v, 1'b0, 0);
    end
    chk("t3_full", fifo_full, 1);
    chk("t3_ovr", ovr_flag, 1);
    chk("t3_level", fifo_level, 8);
    chk("t3_head", rd_data, 32'h11);
    for (int i = 0; i < 8; i++) pop_one();
    chk("t3_empty", fifo_empty, 1);
    chk("t3_rd_zero", rd_data, 0);
    chk("t3_ovr_sticky", ovr_flag, 1);
    pop_one();
    chk("t3_empty_pop_level", fifo_level, 0);
    ovr_clr = 1'b1;
    @(posedge clk_rx); #1;
    ovr_clr = 1'b0;
    chk("t3_ovr_clr", ovr_flag, 0);

    // 4: full FIFO, pop on the completion edge of frame 9
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(32'(i));
      send_frame(8, 32'(i), 1'b0, 0);
    end
    chk("t4_full_before", fifo_full, 1);
    exp_q.push_back(32'h9);
    send_frame(8, 32'h9, 1'b0, 1);
    chk("t4_ovr", ovr_flag, 0);
    chk("t4_level", fifo_level, 8);
    chk("t4_full_after", fifo_full, 1);
    for (int i = 0; i < 8; i++) pop_one();
    chk("t4_empty", fifo_empty, 1);

    // 5: abort mid-frame, then frame counting against spi_tnum=3
    spi_tnum = 13'd3;
    #1;
    chk("t5_done_init", rx_done, 0);
    exp_q.push_back(32'h5A);
    send_frame(8, 32'h5A, 1'b0, 0);
    exp_q.push_back(32'hC3);
    send_frame(8, 32'hC3, 1'b0, 0);
    chk("t5_done_2", rx_done, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 5'd7);
    chk("t5_busy_partial", rx_busy, 1);
    idle(1);
    chk("t5_busy_abort", rx_busy, 0);
    chk("t5_level_abort", fifo_level, 2);
    exp_q.push_back(32'h3C);
    send_frame(8, 32'h3C, 1'b0, 0);
    exp_q.push_back(32'h0F);
    send_frame(8, 32'h0F, 1'b0, 0);
    chk("t5_done_cleared", rx_done, 0);
    exp_q.push_back(32'hF0);
    send_frame(8, 32'hF0, 1'b0, 0);
    chk("t5_done_3", rx_done, 1);
    exp_q.push_back(32'h77);
    send_frame(8, 32'h77, 1'b0, 0);
    chk("t5_done_4", rx_done, 1);
    chk("t5_level", fifo_level, 6);
    for (int i = 0; i < 6; i++) pop_one();

    // 6: frame_len 7->15 at bit 3 of an 8-bit frame (0x96), then a 16-bit frame
    exp_q.push_back(32'h96);
    v = 32'h96;
    lsbf = 1'b0;
    for (int k = 0; k < 8; k++) send_bit(v[7-k], (k < 3) ? 5'd7 : 5'd15);
    rx_en = 1'b0;
    chk("t6_busy_after8", rx_busy, 0);
    chk("t6_level1", fifo_level, 1);
    chk("t6_peek", rd_data, 32'h96);
    exp_q.push_back(32'hBEEF);
    send_frame(16, 32'hBEEF, 1'b0, 0);
    chk("t6_level2", fifo_level, 2);
    pop_one();
    pop_one();
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
